des_key_sched_ctrl: RTL and testbench

Iterative DES key-schedule controller. It replaces the 16-stage unrolled subkey chain with one C/D register pair plus a round counter, and emits one 48-bit subkey per accepted handshake. Emission order is K1..K16 for encryption and K16..K1 for decryption, where decryption uses right rotations. It sits between key load and the iterative Feistel round engine, which consumes one subkey per round over a valid/ready handshake.

---
 rtl/des_pkg.sv | 63 ++++++
 rtl/des_key_sched_ctrl_if.sv | 25 ++
 rtl/des_pc2.sv | 13 +
 rtl/des_key_sched_ctrl.sv | 100 ++++++++++
 tb/tb_des_key_sched_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared constants and helpers for the iterative DES key schedule:
// shift schedule, PC2 selection table, controller states and 28-bit rotates.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int CD_W       = 56;
    localparam int SK_W       = 48;

    localparam logic [3:0] LAST_RND = 4'd15;

    // Left-rotate amount for DES rounds 1..16, stored at index round-1.
    localparam logic [1:0] SHIFT_SCHED [0:NUM_ROUNDS-1] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [5:0] PC2_TAB [0:SK_W-1] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {x[26:0], x[27]};
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {x[0], x[27:1]};
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    // C and D halves rotate independently; C occupies the upper 28 bits.
    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Handshake bundle between key loader / round engine and the key-schedule controller.
interface des_key_sched_ctrl_if;
    import des_pkg::*;

    logic            start;
    logic            decrypt;
    logic [1:CD_W]   key_in;
    logic            subkey_ready;
    logic            subkey_valid;
    logic [1:SK_W]   subkey;
    logic [3:0]      round_idx;
    logic            busy;
    logic            done;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey_valid, subkey, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey_valid, subkey, round_idx, busy, done
    );

endinterface

// File: rtl/des_pc2.sv
// Permuted choice 2: selects 48 of the 56 C/D bits (DES bit numbering, bit 1 = MSB).
module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W] cd,
    output logic [1:SK_W] subkey
);

    for (genvar i = 0; i < SK_W; i++) begin : g_bit
        assign subkey[i+1] = cd[PC2_TAB[i]];
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule controller: one C/D register pair and a round counter
// emit K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_sched_ctrl
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    des_key_sched_ctrl_if.slave bus
);

    state_e        state_r, state_s;
    logic [55:0]   cd_r, cd_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          dir_r, dir_s;
    logic          valid_r, busy_r, done_r;
    logic [3:0]    ridx_r, ridx_s;
    logic          handshake_s;
    logic [1:SK_W] subkey_s;

    assign handshake_s = valid_r & bus.subkey_ready;

    // Next-state and C/D advance. Decrypt loads C0D0 directly because the
    // total rotation over 16 rounds is 28, so C16D16 == C0D0.
    always_comb begin
        state_s = state_r;
        cd_s    = cd_r;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        case (state_r)
            IDLE: begin
                cnt_s = 4'd0;
                if (bus.start) begin
                    dir_s   = bus.decrypt;
                    cd_s    = bus.decrypt ? bus.key_in : rotl_cd(bus.key_in, 2'd1);
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (handshake_s) begin
                    if (cnt_r == LAST_RND) begin
                        state_s = DONE;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                        cd_s  = dir_r ? rotr_cd(cd_r, SHIFT_SCHED[LAST_RND - cnt_r])
                                      : rotl_cd(cd_r, SHIFT_SCHED[cnt_r + 4'd1]);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    assign ridx_s = dir_s ? (LAST_RND - cnt_s) : cnt_s;

    // State, key register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cd_r    <= 56'd0;
            cnt_r   <= 4'd0;
            dir_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ridx_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            cd_r    <= cd_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            valid_r <= (state_s == RUN);
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            ridx_r  <= ridx_s;
        end
    end

    des_pc2 u_pc2 (
        .cd     (cd_r),
        .subkey (subkey_s)
    );

    assign bus.subkey       = subkey_s;
    assign bus.subkey_valid = valid_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.round_idx    = ridx_r;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench: expected subkeys from a per-round reference key schedule are
// queued at start; an independent monitor pops and compares on every handshake.
module tb_des_key_sched_ctrl;

    logic clk;
    logic rst_n;
    logic rdy_mode;
    int   n_cmp;
    int   n_bad;

    des_key_sched_ctrl_if bus ();

    des_key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [55:0] KEY_TV = 56'hF0CCAAF556678F;
    localparam logic [47:0] K1_TV  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_TV = 48'hCB3D8B0E17F5;

    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int pc2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic [47:0] ref_ks [16];
    logic [47:0] exp_sk [$];
    logic [3:0]  exp_idx [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook key schedule: cumulative left shifts from C0/D0, PC2 of each CiDi.
    task automatic build_ref(input logic [55:0] k);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] sk;
        c = k[55:28];
        d = k[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < shifts[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int b = 0; b < 48; b++) sk[47-b] = cd[56-pc2[b]];
            ref_ks[r] = sk;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sched(input logic [55:0] k, input logic dec);
        tick();
        build_ref(k);
        for (int i = 0; i < 16; i++) begin
            int r;
            r = dec ? 15 - i : i;
            exp_sk.push_back(ref_ks[r]);
            exp_idx.push_back(4'(r));
        end
        bus.start   = 1'b1;
        bus.key_in  = k;
        bus.decrypt = dec;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk("done_seen", 64'(seen), 64'd1);
        tick();
    endtask

    // Ready driver: always high, or pseudo-random backpressure.
    initial begin
        bus.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.subkey_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: handshake compare, hold stability, done one cycle after 16th handshake.
    initial begin
        logic        hold;
        logic [47:0] hold_sk;
        logic [3:0]  hold_idx;
        logic        done_due;
        int          hs_cnt;
        hold = 1'b0; hold_sk = 48'd0; hold_idx = 4'd0; done_due = 1'b0; hs_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0; done_due = 1'b0; hs_cnt = 0;
            end else begin
                chk("done_pulse", 64'(bus.done), 64'(done_due));
                done_due = 1'b0;
                if (hold) begin
                    chk("hold_valid", 64'(bus.subkey_valid), 64'd1);
                    chk("hold_subkey", 64'(bus.subkey), 64'(hold_sk));
                    chk("hold_idx", 64'(bus.round_idx), 64'(hold_idx));
                end
                hold     = bus.subkey_valid && !bus.subkey_ready;
                hold_sk  = bus.subkey;
                hold_idx = bus.round_idx;
                if (bus.subkey_valid && bus.subkey_ready) begin
                    if (exp_sk.size() == 0) begin
                        chk("unexpected_subkey", 64'(bus.subkey), 64'd0);
                        chk("unexpected_hs", 64'd1, 64'd0);
                    end else begin
                        chk("subkey", 64'(bus.subkey), 64'(exp_sk.pop_front()));
                        chk("round_idx", 64'(bus.round_idx), 64'(exp_idx.pop_front()));
                    end
                    hs_cnt++;
                    if (hs_cnt == 16) begin
                        done_due = 1'b1;
                        hs_cnt   = 0;
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rdy_mode = 1'b0;
        rst_n = 1'b1;
        bus.start = 1'b0; bus.decrypt = 1'b0; bus.key_in = 56'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_idx", 64'(bus.round_idx), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Encrypt known vector, ready held high.
        start_sched(KEY_TV, 1'b0);
        @(negedge clk);
        chk("enc_k1", 64'(bus.subkey), 64'(K1_TV));
        chk("enc_k1_idx", 64'(bus.round_idx), 64'd0);
        chk("enc_k1_busy", 64'(bus.busy), 64'd1);
        for (int c = 2; c <= 16; c++) @(negedge clk);
        chk("enc_k16", 64'(bus.subkey), 64'(K16_TV));
        chk("enc_k16_idx", 64'(bus.round_idx), 64'd15);
        @(negedge clk);
        chk("enc_done_n17", 64'(bus.done), 64'd1);
        tick();

        // Decrypt known vector; start with another key during RUN and in DONE.
        start_sched(KEY_TV, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            bus.start   = (c >= 5 && c <= 7) || (c == 17);
            bus.key_in  = {$urandom, $urandom};
            bus.decrypt = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                chk("dec_first", 64'(bus.subkey), 64'(K16_TV));
                chk("dec_first_idx", 64'(bus.round_idx), 64'd15);
            end
            if (c == 16) begin
                chk("dec_last", 64'(bus.subkey), 64'(K1_TV));
                chk("dec_last_idx", 64'(bus.round_idx), 64'd0);
            end
            if (c == 17) chk("dec_done", 64'(bus.done), 64'd1);
            if (c == 18) begin
                chk("b2b_ignored_busy", 64'(bus.busy), 64'd0);
                chk("b2b_ignored_valid", 64'(bus.subkey_valid), 64'd0);
            end
            tick();
        end
        bus.start = 1'b0;

        // Asynchronous reset mid-schedule, then a fresh encrypt.
        start_sched({$urandom, $urandom}, 1'b0);
        repeat (7) tick();
        #2 rst_n = 1'b0;
        exp_sk.delete();
        exp_idx.delete();
        #1;
        chk("abort_valid", 64'(bus.subkey_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        start_sched(KEY_TV, 1'b0);
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.subkey_valid), 64'd1);
        chk("post_rst_k1", 64'(bus.subkey), 64'(K1_TV));
        wait_done();

        // Random keys, both directions, random backpressure.
        rdy_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [55:0] k;
            k = {$urandom, $urandom};
            start_sched(k, 1'b0);
            wait_done();
            start_sched(k, 1'b1);
            wait_done();
        end
        rdy_mode = 1'b0;
        repeat (3) tick();
        chk("queue_drained", 64'(exp_sk.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
